uart_reg_loader: RTL and testbench

//  Receive-side counterpart of the register-file UART dump. Takes bytes from the UART receiver,

---
 rtl/uart_loader_pkg.sv | 34 +++
 rtl/uart_byte_assembler.sv | 46 ++++
 rtl/uart_reg_loader.sv | 197 +++++++++++++++++++
 tb/tb_uart_reg_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared constants and state encoding for the UART register loader (LOADER_CHECKSUM_EN adds CHECK)
package uart_loader_pkg;

  localparam int BYTES_PER_WORD         = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 5_000_000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_COLLECT = ST_COLLECT,
    S_WRITE   = ST_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK   = ST_CHECK,
`endif
    S_DONE    = ST_DONE
  } state_e;

  // States in which a load is in progress: busy is high and the idle timer runs
  function automatic logic is_active(input state_e s);
    case (s)
      S_COLLECT, S_WRITE: return 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:            return 1'b1;
`endif
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_assembler.sv
// rtl/uart_byte_assembler.sv - packs accepted bytes MSB first into 32-bit words
module uart_byte_assembler
  import uart_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  rx_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;

  // Shift each accepted byte in at the bottom; clr restarts word alignment
  always_comb begin
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    if (clr) begin
      shreg_d    = '0;
      byte_cnt_d = '0;
    end else if (accept) begin
      shreg_d    = {shreg_q[23:0], rx_data};
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  // Shift register and byte counter, cleared by the active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // The completed word is presented in the same cycle as its last byte so the
  // caller can latch it on the edge that takes that byte.
  assign word       = shreg_d;
  assign word_ready = accept && !clr && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/uart_reg_loader.sv
// rtl/uart_reg_loader.sv - loads register-file words from UART bytes (LOADER_CHECKSUM_EN enables trailing XOR check)
module uart_reg_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 5,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int NUM_WORDS      = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic [ADDR_BUS_WIDTH-1:0] wr_addr,
  output logic [DATA_BUS_WIDTH-1:0] wr_data,
  output logic                      wr_en,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err,
  output logic                      chk_err
);

  localparam int                        TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]             TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_BUS_WIDTH-1:0] LAST_IDX   = ADDR_BUS_WIDTH'(NUM_WORDS - 1);

  state_e                    state_q, state_d;
  logic [ADDR_BUS_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [ADDR_BUS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BUS_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      wr_en_q, wr_en_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      timeout_err_q, timeout_err_d;

  logic                      asm_clr;
  logic                      asm_accept;
  logic                      word_ready;
  logic [31:0]               word;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]                xor_q, xor_d;
  logic                      chk_err_q, chk_err_d;
`endif

  uart_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .accept     (asm_accept),
    .rx_data    (rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  // Next-state, idle timer and registered-output computation for the load sequence
  always_comb begin
    state_d       = state_q;
    word_idx_d    = word_idx_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;
    asm_clr       = 1'b0;
    asm_accept    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    xor_d         = xor_q;
    chk_err_d     = chk_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A byte arriving here, even alongside start, is dropped
        if (start) begin
          state_d       = S_COLLECT;
          asm_clr       = 1'b1;
          word_idx_d    = '0;
          timeout_err_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          xor_d         = '0;
          chk_err_d     = 1'b0;
`endif
        end
      end
      S_COLLECT: begin
        asm_accept = rx_valid;
        if (word_ready) begin
          state_d   = S_WRITE;
          wr_addr_d = word_idx_q;
          wr_data_d = word;
        end
      end
      S_WRITE: begin
        // A byte landing during the write strobe starts the next word
        asm_accept = rx_valid;
        word_idx_d = word_idx_q + 1'b1;
        if (word_idx_q == LAST_IDX) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_COLLECT;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) begin
          chk_err_d = (rx_data != xor_q);
          state_d   = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef LOADER_CHECKSUM_EN
    if (asm_accept) begin
      xor_d = xor_q ^ rx_data;
    end
`endif

    // Inter-byte watchdog: any byte restarts it, expiry abandons the load
    if (is_active(state_q)) begin
      if (rx_valid) begin
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
        if (timer_d == TIMER_LAST) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b1;
          timer_d       = '0;
        end
      end
    end else begin
      timer_d = '0;
    end

    busy_d  = is_active(state_d);
    done_d  = (state_d == S_DONE);
    wr_en_d = (state_d == S_WRITE);
  end

  // State and output registers, all cleared by the active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      word_idx_q    <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      timer_q       <= '0;
      wr_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q         <= '0;
      chk_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      word_idx_q    <= word_idx_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      timer_q       <= timer_d;
      wr_en_q       <= wr_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q         <= xor_d;
      chk_err_q     <= chk_err_d;
`endif
    end
  end

  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_en       = wr_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
`ifdef LOADER_CHECKSUM_EN
  assign chk_err     = chk_err_q;
`else
  assign chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_reg_loader.sv
// tb/tb_uart_reg_loader.sv - directed self-checking bench for uart_reg_loader (LOADER_CHECKSUM_EN adds checksum steps)
module tb_uart_reg_loader;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NW = 32;
  localparam int TO = 100;

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          start    = 1'b0;
  logic [7:0]    rx_data  = 8'h00;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic          chk_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [AW+DW-1:0] wq[$];

  always #5 clk = ~clk;

  uart_reg_loader #(
    .ADDR_BUS_WIDTH (AW),
    .DATA_BUS_WIDTH (DW),
    .NUM_WORDS      (NW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .chk_err     (chk_err)
  );

  // Register-file side: record every write strobe at the falling edge
  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back({wr_addr, wr_data});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Word k = 0x100*k + k, bytes 00 00 k k, sent back to back
  task automatic send_load();
    for (int k = 0; k < NW; k++) begin
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'(k));
      send_byte(8'(k));
    end
  endtask

  initial begin
    tick(2);
    check("reset_outputs", {wr_addr, wr_data, wr_en, busy, done, timeout_err, chk_err}, 64'd0);
    rst = 1'b1;
    tick(1);

    pulse_start();
    check("t1_busy_after_start", busy, 1);
    send_load();
    check("t1_last_write", {wr_en, wr_addr}, {1'b1, 5'd31});
    tick(1);
`ifdef LOADER_CHECKSUM_EN
    check("t1_wait_checksum", {busy, done}, 2'b10);
    send_byte(8'h00);
`endif
    check("t1_done", {done, busy, chk_err}, 3'b100);
    tick(1);
    check("t1_done_one_cycle", done, 0);
    check("t1_write_count", wq.size(), 32);
    for (int i = 0; i < NW && i < wq.size(); i++) begin
      check($sformatf("t1_word%0d", i), wq[i], {5'(i), 32'(i * 257)});
    end

    pulse_start();
    send_byte(8'hDE); tick(1);
    send_byte(8'hAD); tick(1);
    send_byte(8'hBE); tick(1);
    check("t2_no_early_write", wr_en, 0);
    send_byte(8'hEF);
    check("t2_write_next_cycle", {wr_en, wr_addr, wr_data}, {1'b1, 5'd0, 32'hDEADBEEF});
    tick(1);
    check("t2_strobe_one_cycle_data_held", {wr_en, wr_data}, {1'b0, 32'hDEADBEEF});

    send_byte(8'h11);
    send_byte(8'h22);
    tick(98);
    check("t3_before_timeout", {timeout_err, busy}, 2'b01);
    tick(1);
    check("t3_timeout", {timeout_err, busy, done}, 3'b100);
    check("t3_one_write", wq.size(), 33);

    send_byte(8'hAA);
    check("t5_idle_byte_ignored", {busy, wr_en}, 2'b00);
    start    = 1'b1;
    rx_data  = 8'hBB;
    rx_valid = 1'b1;
    tick(1);
    start    = 1'b0;
    rx_valid = 1'b0;
    check("t5_start_clears_timeout", {busy, timeout_err}, 2'b10);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    check("t5_dropped_byte_not_counted", wr_en, 0);
    send_byte(8'hC4);
    check("t5_word0", {wr_en, wr_addr, wr_data}, {1'b1, 5'd0, 32'hC1C2C3C4});
    tick(1);
    pulse_start();
    send_byte(8'hD1);
    send_byte(8'hD2);
    send_byte(8'hD3);
    send_byte(8'hD4);
    check("t5_start_ignored_while_busy", {wr_en, wr_addr, wr_data}, {1'b1, 5'd1, 32'hD1D2D3D4});
    tick(1);

    send_byte(8'hE1);
    send_byte(8'hE2);
    rst = 1'b0;
    tick(1);
    check("t4_reset_outputs", {wr_addr, wr_data, wr_en, busy, done, timeout_err, chk_err}, 64'd0);
    rst = 1'b1;
    tick(1);
    check("t4_no_partial_write", wq.size(), 35);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    check("t4_word_after_reset", {wr_en, wr_addr, wr_data}, {1'b1, 5'd0, 32'h01020304});
    tick(1);
    check("t4_write_count", wq.size(), 36);

`ifdef LOADER_CHECKSUM_EN
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    pulse_start();
    send_load();
    tick(1);
    send_byte(8'h5A);
    check("t6_bad_checksum", {done, chk_err}, 2'b11);
    tick(1);
    check("t6_chk_err_sticky", {done, chk_err}, 2'b01);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
